// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter
//   Round-robin, packet-locking arbiter that shares one router output port
//   among N_REQ input requesters. A winner is chosen in IDLE (one bubble
//   cycle), then its flits are passed through a single registered output
//   stage until the flit marked last has been accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester flit valid
//   req_last   per-requester flit is last of its packet
//   req_data   per-requester flit, packed [N_REQ-1:0][DATA_W-1:0]
//   req_ready  per-requester flit accepted (combinational)
//   out_valid  output flit valid (registered)
//   out_data   output flit (registered)
//   out_last   output flit is last of packet (registered)
//   out_ready  downstream accepts the output flit
//   grant_id   index of the locked requester (registered)
//   busy       high while a packet is locked
module rr_port_arbiter #(
    parameter int N_REQ  = 5,
    parameter int DATA_W = 32,
    parameter int PORT_W = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_last,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic [PORT_W-1:0]              grant_id,
    output logic                           busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [PORT_W-1:0] PTR_RST = PORT_W'(N_REQ - 1);
    localparam logic [PORT_W:0]   N_WIDE  = (PORT_W + 1)'(N_REQ);

    state_t              state_r, state_nxt_s;
    logic [PORT_W-1:0]   ptr_r, ptr_nxt_s;
    logic [PORT_W-1:0]   grant_r, grant_nxt_s;
    logic                out_valid_r, out_valid_nxt_s;
    logic [DATA_W-1:0]   out_data_r, out_data_nxt_s;
    logic                out_last_r, out_last_nxt_s;

    logic                win_found_s;
    logic [PORT_W-1:0]   win_idx_s;
    logic [PORT_W:0]     cand_s;
    logic [N_REQ-1:0]    req_ready_s;
    logic                accept_s;

    // Round-robin search: first valid requester after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = {1'b0, ptr_r} + (PORT_W + 1)'(k);
            if (cand_s >= N_WIDE) begin
                cand_s = cand_s - N_WIDE;
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_valid[cand_s[PORT_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[PORT_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Only the locked requester may see ready, and only when the output slot frees up.
    always_comb begin
        req_ready_s = '0;
        if (state_r == LOCK) begin
            req_ready_s[grant_r] = !out_valid_r || out_ready;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state and output-register update for the IDLE/LOCK FSM.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        grant_nxt_s     = grant_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        out_last_nxt_s  = out_last_r;
        accept_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    grant_nxt_s = win_idx_s;
                    state_nxt_s = LOCK;
                end else begin
                    state_nxt_s = IDLE;
                end
                // The output register keeps draining during the arbitration bubble.
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            LOCK: begin
                accept_s = req_valid[grant_r] && req_ready_s[grant_r];
                if (accept_s) begin
                    out_data_nxt_s  = req_data[grant_r];
                    out_last_nxt_s  = req_last[grant_r];
                    out_valid_nxt_s = 1'b1;
                    if (req_last[grant_r]) begin
                        // Next search starts just after the requester that finished.
                        ptr_nxt_s   = grant_r;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = LOCK;
                    end
                end else if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer, grant and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= PTR_RST;
            grant_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            grant_r     <= grant_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
        end
    end

    assign req_ready = req_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign grant_id  = grant_r;
    assign busy      = (state_r == LOCK);

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter
//   Directed bench for rr_port_arbiter (N_REQ=5, DATA_W=32, PORT_W=3).
//   Inputs change 1 time unit after each rising edge; registered outputs are
//   sampled at that point, combinational ready after a further unit.
module tb_rr_port_arbiter;

    logic                clk;
    logic                rst_n;
    logic [4:0]          req_valid;
    logic [4:0]          req_last;
    logic [4:0][31:0]    req_data;
    logic [4:0]          req_ready;
    logic                out_valid;
    logic [31:0]         out_data;
    logic                out_last;
    logic                out_ready;
    logic [2:0]          grant_id;
    logic                busy;

    int n_pass;
    int n_total;

    rr_port_arbiter #(
        .N_REQ  (5),
        .DATA_W (32),
        .PORT_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [2:0] exp_g [4];
        n_pass    = 0;
        n_total   = 0;
        exp_g[0]  = 3'd0;
        exp_g[1]  = 3'd2;
        exp_g[2]  = 3'd4;
        exp_g[3]  = 3'd0;
        rst_n     = 1'b0;
        req_valid = 5'b00000;
        req_last  = 5'b00000;
        req_data  = '0;
        out_ready = 1'b1;
        tick;
        tick;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        tick;

        // Single-flit packets from 0,2,4: order A0,A2,A4,A0, one every 2 cycles
        req_valid = 5'b10101;
        req_last  = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            req_data[i] = 32'hA0 + 32'(i);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_grant", 32'(grant_id), 32'(exp_g[k]));
            check("rr_busy", 32'(busy), 32'd1);
            check("rr_bubble_valid", 32'(out_valid), 32'd0);
            check("rr_ready", 32'(req_ready), 32'd1 << exp_g[k]);
            tick;
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_data", out_data, 32'hA0 + 32'(exp_g[k]));
            check("rr_last", 32'(out_last), 32'd1);
            check("rr_idle", 32'(busy), 32'd0);
        end

        // Req4 finishes (ptr=4), then req0 and req4 both valid: wrap to 0
        req_valid = 5'b10000;
        tick;
        check("wrap_pre_grant", 32'(grant_id), 32'd4);
        tick;
        check("wrap_pre_data", out_data, 32'hA4);
        req_valid = 5'b10001;
        tick;
        check("wrap_grant", 32'(grant_id), 32'd0);
        check("wrap_busy", 32'(busy), 32'd1);
        tick;
        check("wrap_data", out_data, 32'hA0);
        req_valid = 5'b00000;
        tick;

        // Req1 three-flit packet with req3 waiting throughout
        req_valid   = 5'b01010;
        req_last    = 5'b01000;
        req_data[1] = 32'h11;
        req_data[3] = 32'h31;
        tick;
        check("pkt_grant", 32'(grant_id), 32'd1);
        #1;
        check("pkt_ready", 32'(req_ready), 32'b00010);
        tick;
        check("pkt_d0", out_data, 32'h11);
        check("pkt_d0_valid", 32'(out_valid), 32'd1);
        check("pkt_d0_last", 32'(out_last), 32'd0);
        req_data[1] = 32'h12;
        tick;
        check("pkt_d1", out_data, 32'h12);
        check("pkt_d1_valid", 32'(out_valid), 32'd1);
        check("pkt_d1_grant", 32'(grant_id), 32'd1);
        req_data[1] = 32'h13;
        req_last    = 5'b01010;
        tick;
        check("pkt_d2", out_data, 32'h13);
        check("pkt_d2_last", 32'(out_last), 32'd1);
        check("pkt_d2_busy", 32'(busy), 32'd0);
        req_valid = 5'b01000;
        tick;
        check("pkt_gap_valid", 32'(out_valid), 32'd0);
        check("pkt_next_grant", 32'(grant_id), 32'd3);
        tick;
        check("pkt_req3_data", out_data, 32'h31);
        check("pkt_req3_valid", 32'(out_valid), 32'd1);

        // Backpressure for 4 cycles mid-packet
        req_valid   = 5'b00001;
        req_last    = 5'b00000;
        req_data[0] = 32'h40;
        tick;
        check("bp_grant", 32'(grant_id), 32'd0);
        check("bp_drain", 32'(out_valid), 32'd0);
        tick;
        check("bp_d0", out_data, 32'h40);
        req_data[0] = 32'h41;
        out_ready   = 1'b0;
        #1;
        check("bp_ready_off", 32'(req_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, 32'h40);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_on", 32'(req_ready), 32'b00001);
        tick;
        check("bp_d1", out_data, 32'h41);
        check("bp_d1_valid", 32'(out_valid), 32'd1);
        req_data[0] = 32'h42;
        req_last    = 5'b00001;
        tick;
        check("bp_d2", out_data, 32'h42);
        check("bp_d2_last", 32'(out_last), 32'd1);
        req_valid = 5'b00000;
        tick;
        check("bp_drained", 32'(out_valid), 32'd0);

        // Req2 drops valid mid-packet while req0 waits
        req_valid   = 5'b00100;
        req_last    = 5'b00000;
        req_data[2] = 32'h61;
        tick;
        check("drop_grant", 32'(grant_id), 32'd2);
        tick;
        check("drop_d0", out_data, 32'h61);
        req_valid   = 5'b00001;
        req_last    = 5'b00001;
        req_data[0] = 32'h70;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("drop_hold_grant", 32'(grant_id), 32'd2);
            check("drop_hold_busy", 32'(busy), 32'd1);
            check("drop_hold_ready", 32'(req_ready), 32'b00100);
            check("drop_hold_valid", 32'(out_valid), 32'd0);
        end
        req_valid   = 5'b00101;
        req_last    = 5'b00101;
        req_data[2] = 32'h62;
        tick;
        check("drop_d1", out_data, 32'h62);
        check("drop_d1_last", 32'(out_last), 32'd1);
        check("drop_done", 32'(busy), 32'd0);
        req_valid = 5'b00001;
        tick;
        check("drop_next_grant", 32'(grant_id), 32'd0);
        check("drop_next_busy", 32'(busy), 32'd1);
        check("drop_next_ready", 32'(req_ready), 32'b00001);

        // Asynchronous reset mid-packet, observed before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        check("arst_grant", 32'(grant_id), 32'd0);
        tick;
        req_valid = 5'b00000;
        rst_n     = 1'b1;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
